// File: rtl/alu_op_issue_stage.sv
// Purpose : decode one RV64I instruction per handshake into a one-hot ALU op plus both operands.
// Latency : 1 cycle from accept to out_* when the 2-entry skid buffer is empty.
// Backpr. : in_ready is registered and drops only when both entries are held; out_* hold while stalled.
// Option  : ALU_ISSUE_ILLEGAL_CHK_EN drives out_illegal for illegal encodings (otherwise tied 0).
module alu_op_issue_stage #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_alu_control,
    output logic [XLEN-1:0]   out_alu_src1,
    output logic [XLEN-1:0]   out_alu_src2,
    output logic [XLEN-1:0]   out_pc,
    output logic              out_illegal
);

    localparam logic [CTRL_W-1:0] C_ADD  = CTRL_W'(1 << 0);
    localparam logic [CTRL_W-1:0] C_SUB  = CTRL_W'(1 << 1);
    localparam logic [CTRL_W-1:0] C_SLT  = CTRL_W'(1 << 2);
    localparam logic [CTRL_W-1:0] C_SLTU = CTRL_W'(1 << 3);
    localparam logic [CTRL_W-1:0] C_AND  = CTRL_W'(1 << 4);
    localparam logic [CTRL_W-1:0] C_OR   = CTRL_W'(1 << 5);
    localparam logic [CTRL_W-1:0] C_XOR  = CTRL_W'(1 << 6);
    localparam logic [CTRL_W-1:0] C_SLL  = CTRL_W'(1 << 7);
    localparam logic [CTRL_W-1:0] C_SRL  = CTRL_W'(1 << 8);
    localparam logic [CTRL_W-1:0] C_SRA  = CTRL_W'(1 << 9);
    localparam logic [CTRL_W-1:0] C_LUI  = CTRL_W'(1 << 10);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   src1;
        logic [XLEN-1:0]   src2;
        logic [XLEN-1:0]   pc;
        logic              illegal;
    } entry_t;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

    // instruction fields and pre-formatted immediates
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [5:0]      funct6;
    logic [XLEN-1:0] imm_i, imm_s, imm_u, lui_imm, shamt;

    assign opcode  = in_inst[6:0];
    assign funct3  = in_inst[14:12];
    assign funct7  = in_inst[31:25];
    assign funct6  = in_inst[31:26];
    assign imm_i   = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
    assign imm_s   = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_u   = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
    assign lui_imm = {{(XLEN-20){1'b0}}, in_inst[31:12]};
    assign shamt   = {{(XLEN-6){1'b0}}, in_inst[25:20]};

    logic [CTRL_W-1:0] dec_ctrl;
    logic [XLEN-1:0]   dec_src1, dec_src2;
    entry_t            dec;

    // decode: an encoding is legal exactly when some control bit gets set
    always_comb begin
        dec_ctrl = '0;
        dec_src1 = in_rs1_data;
        dec_src2 = in_rs2_data;
        case (opcode)
            OPC_OP_IMM: begin
                dec_src2 = imm_i;
                case (funct3)
                    3'b000: dec_ctrl = C_ADD;
                    3'b010: dec_ctrl = C_SLT;
                    3'b011: dec_ctrl = C_SLTU;
                    3'b100: dec_ctrl = C_XOR;
                    3'b110: dec_ctrl = C_OR;
                    3'b111: dec_ctrl = C_AND;
                    3'b001: begin
                        dec_src2 = shamt;
                        if (funct6 == 6'b000000) dec_ctrl = C_SLL;
                    end
                    default: begin
                        dec_src2 = shamt;
                        if (funct6 == 6'b000000)      dec_ctrl = C_SRL;
                        else if (funct6 == 6'b010000) dec_ctrl = C_SRA;
                    end
                endcase
            end
            OPC_OP: begin
                case ({funct7, funct3})
                    10'b0000000_000: dec_ctrl = C_ADD;
                    10'b0100000_000: dec_ctrl = C_SUB;
                    10'b0000000_001: dec_ctrl = C_SLL;
                    10'b0000000_010: dec_ctrl = C_SLT;
                    10'b0000000_011: dec_ctrl = C_SLTU;
                    10'b0000000_100: dec_ctrl = C_XOR;
                    10'b0000000_101: dec_ctrl = C_SRL;
                    10'b0100000_101: dec_ctrl = C_SRA;
                    10'b0000000_110: dec_ctrl = C_OR;
                    10'b0000000_111: dec_ctrl = C_AND;
                    default:         dec_ctrl = '0;
                endcase
            end
            OPC_LUI: begin
                dec_ctrl = C_LUI;
                dec_src1 = '0;
                dec_src2 = lui_imm;
            end
            OPC_AUIPC: begin
                dec_ctrl = C_ADD;
                dec_src1 = in_pc;
                dec_src2 = imm_u;
            end
            OPC_JAL: begin
                dec_ctrl = C_ADD;
                dec_src1 = in_pc;
                dec_src2 = XLEN'(4);
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) dec_ctrl = C_ADD;
                dec_src1 = in_pc;
                dec_src2 = XLEN'(4);
            end
            OPC_LOAD: begin
                if (funct3 != 3'b111) dec_ctrl = C_ADD;
                dec_src2 = imm_i;
            end
            OPC_STORE: begin
                if (!funct3[2]) dec_ctrl = C_ADD;
                dec_src2 = imm_s;
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: dec_ctrl = C_SUB;
                    3'b100, 3'b101: dec_ctrl = C_SLT;
                    3'b110, 3'b111: dec_ctrl = C_SLTU;
                    default:        dec_ctrl = '0;
                endcase
            end
            default: dec_ctrl = '0;
        endcase
        if (dec_ctrl == '0) begin
            dec_src1 = '0;
            dec_src2 = '0;
        end
    end

    assign dec = '{ctrl: dec_ctrl, src1: dec_src1, src2: dec_src2, pc: in_pc,
                   illegal: (dec_ctrl == '0)};

    state_t state, state_nxt;
    logic   in_ready_q;
    logic   accept, pop;
    entry_t buf_q [2];
    logic   wr_ptr, rd_ptr;
    entry_t head;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // state register plus the registered copy of in_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != S_FULL);
        end
    end

    // next-state: occupancy tracking, flush overrides everything
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: if (accept) state_nxt = S_ONE;
                S_ONE: begin
                    if (accept && !pop)      state_nxt = S_FULL;
                    else if (pop && !accept) state_nxt = S_EMPTY;
                end
                S_FULL:  if (pop) state_nxt = S_ONE;
                default: state_nxt = S_EMPTY;
            endcase
        end
    end

    // outputs derived from the state register
    always_comb begin
        out_valid = (state != S_EMPTY);
        in_ready  = in_ready_q;
    end

    // two-entry storage; a write into an empty buffer lands at the head
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (accept) begin
                buf_q[wr_ptr] <= dec;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
        end
    end

    assign head            = buf_q[rd_ptr];
    assign out_alu_control = head.ctrl;
    assign out_alu_src1    = head.src1;
    assign out_alu_src2    = head.src2;
    assign out_pc          = head.pc;

`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
    assign out_illegal = head.illegal;
`else
    logic unused_illegal;
    assign unused_illegal = head.illegal;
    assign out_illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_issue_stage.sv
// Randomized and directed bench for alu_op_issue_stage with a queue-based reference model.
module tb_alu_op_issue_stage;

`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_inst;
    logic [63:0] in_pc, in_rs1_data, in_rs2_data, out_alu_src1, out_alu_src2, out_pc;
    logic [10:0] out_alu_control;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_op_issue_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_control(out_alu_control), .out_alu_src1(out_alu_src1),
        .out_alu_src2(out_alu_src2), .out_pc(out_pc), .out_illegal(out_illegal)
    );

    typedef struct {
        logic [10:0] ctrl;
        logic [63:0] s1, s2, pc;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc, rs1, rs2;
        logic [10:0] ctrl;
        logic [63:0] s1, s2;
        logic        ill;
    } vec_t;

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Build a random instruction from a chosen operation class and state what the ALU must see.
    function automatic void gen(input logic [63:0] pc, rs1, rs2,
                                output logic [31:0] inst, output exp_t e);
        logic [4:0]  rd   = 5'($urandom);
        logic [4:0]  r1   = 5'($urandom);
        logic [4:0]  r2   = 5'($urandom);
        logic [11:0] imm  = 12'($urandom);
        logic [19:0] u    = 20'($urandom);
        logic [5:0]  sh   = 6'($urandom);
        logic [24:0] rnd  = 25'($urandom);
        logic [2:0]  f3;
        int          kind = $urandom_range(0, 10);
        int          p;
        int          op_bit = 0;
        logic [2:0]  imm_f3 [6] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
        int          imm_bt [6] = '{0, 2, 3, 6, 5, 4};
        logic [6:0]  r_f7   [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
        logic [2:0]  r_f3   [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
        int          r_bt   [10] = '{0, 1, 7, 2, 3, 6, 8, 9, 5, 4};
        logic [2:0]  b_f3   [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        int          b_bt   [6] = '{1, 1, 2, 2, 3, 3};
        e.pc = pc; e.ill = 1'b0; e.s1 = rs1; e.s2 = rs2;
        case (kind)
            0: begin
                p = $urandom_range(0, 5);
                inst = {imm, r1, imm_f3[p], rd, 7'h13};
                e.s2 = {{52{imm[11]}}, imm}; op_bit = imm_bt[p];
            end
            1: begin
                p = $urandom_range(0, 2);
                inst = {(p == 2) ? 6'b010000 : 6'b000000, sh, r1, (p == 0) ? 3'd1 : 3'd5, rd, 7'h13};
                e.s2 = {58'b0, sh}; op_bit = 7 + p;
            end
            2: begin
                p = $urandom_range(0, 9);
                inst = {r_f7[p], r2, r1, r_f3[p], rd, 7'h33}; op_bit = r_bt[p];
            end
            3: begin
                inst = {u, rd, 7'h37}; e.s1 = '0; e.s2 = {44'b0, u}; op_bit = 10;
            end
            4: begin
                inst = {u, rd, 7'h17}; e.s1 = pc; e.s2 = {{32{u[19]}}, u, 12'b0};
            end
            5: begin
                inst = {u, rd, 7'h6F}; e.s1 = pc; e.s2 = 64'd4;
            end
            6: begin
                inst = {imm, r1, 3'd0, rd, 7'h67}; e.s1 = pc; e.s2 = 64'd4;
            end
            7: begin
                f3 = 3'($urandom_range(0, 6));
                inst = {imm, r1, f3, rd, 7'h03}; e.s2 = {{52{imm[11]}}, imm};
            end
            8: begin
                f3 = 3'($urandom_range(0, 3));
                inst = {imm[11:5], r2, r1, f3, imm[4:0], 7'h23}; e.s2 = {{52{imm[11]}}, imm};
            end
            9: begin
                p = $urandom_range(0, 5);
                inst = {imm[11:5], r2, r1, b_f3[p], imm[4:0], 7'h63}; op_bit = b_bt[p];
            end
            default: begin
                p = $urandom_range(0, 4);
                case (p)
                    0: inst = 32'h0000_0000;
                    1: inst = {rnd, 7'h1B};
                    2: inst = {rnd, 7'h3B};
                    3: inst = {7'h01, r2, r1, 3'($urandom), rd, 7'h33};
                    default: inst = {imm[11:5], r2, r1, 3'd2, imm[4:0], 7'h63};
                endcase
                e.s1 = '0; e.s2 = '0; e.ill = ILL_EN;
            end
        endcase
        e.ctrl = (kind >= 10) ? 11'd0 : (11'd1 << op_bit);
    endfunction

    task automatic test_reset();
        do_reset();
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_alu_control !== 11'd0) $display("FAIL reset_ctrl got %h want 0", out_alu_control); else n_pass++;
        n_total++; if ({out_alu_src1, out_alu_src2, out_pc} !== 192'd0)
            $display("FAIL reset_data got %h %h %h want 0", out_alu_src1, out_alu_src2, out_pc); else n_pass++;
        n_total++; if (out_illegal !== 1'b0) $display("FAIL reset_illegal got %b want 0", out_illegal); else n_pass++;
    endtask

    task automatic test_directed();
        vec_t v [9] = '{
            '{32'h0050_0093, 64'h1000, 64'd0, 64'd0, 11'h001, 64'd0, 64'd5, 1'b0},
            '{32'h1234_5037, 64'h1004, 64'd7, 64'd8, 11'h400, 64'd0, 64'h12345, 1'b0},
            '{32'h4030_D093, 64'h1008, 64'hF0, 64'd1, 11'h200, 64'hF0, 64'd3, 1'b0},
            '{32'h4020_8033, 64'h100C, 64'd9, 64'd4, 11'h002, 64'd9, 64'd4, 1'b0},
            '{32'h0000_1017, 64'h8000_0000, 64'd1, 64'd2, 11'h001, 64'h8000_0000, 64'h1000, 1'b0},
            '{32'hFFFF_F097, 64'h2000, 64'd1, 64'd2, 11'h001, 64'h2000, 64'hFFFF_FFFF_FFFF_F000, 1'b0},
            '{32'hFE11_3C23, 64'h2004, 64'h300, 64'd5, 11'h001, 64'h300, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0},
            '{32'h0000_0000, 64'h2008, 64'd3, 64'd4, 11'h000, 64'd0, 64'd0, 1'b1},
            '{32'h0010_809B, 64'h200C, 64'd3, 64'd4, 11'h000, 64'd0, 64'd0, 1'b1}
        };
        for (int i = 0; i < 9; i++) begin
            idle();
            in_valid = 1'b1; in_inst = v[i].inst; in_pc = v[i].pc;
            in_rs1_data = v[i].rs1; in_rs2_data = v[i].rs2;
            @(posedge clk); #1;
            idle();
            n_total++; if (out_valid !== 1'b1) $display("FAIL dir%0d_valid got %b want 1", i, out_valid); else n_pass++;
            n_total++; if (out_alu_control !== v[i].ctrl)
                $display("FAIL dir%0d_ctrl got %h want %h", i, out_alu_control, v[i].ctrl); else n_pass++;
            n_total++; if (out_alu_src1 !== v[i].s1 || out_alu_src2 !== v[i].s2 || out_pc !== v[i].pc)
                $display("FAIL dir%0d_data got %h %h %h want %h %h %h", i, out_alu_src1, out_alu_src2, out_pc,
                         v[i].s1, v[i].s2, v[i].pc); else n_pass++;
            n_total++; if (out_illegal !== (v[i].ill & ILL_EN))
                $display("FAIL dir%0d_illegal got %b want %b", i, out_illegal, v[i].ill & ILL_EN); else n_pass++;
            out_ready = 1'b1;
            @(posedge clk); #1;
            idle();
            n_total++; if (out_valid !== 1'b0) $display("FAIL dir%0d_drain got %b want 0", i, out_valid); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int n_acc = 0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_inst = {12'(k + 1), 5'd0, 3'd0, 5'd1, 7'h13}; in_pc = 64'(k * 4);
            @(negedge clk);
            if (in_ready === 1'b1) n_acc++;
            @(posedge clk); #1;
        end
        idle();
        n_total++; if (n_acc != 2) $display("FAIL b2b_accepts got %0d want 2", n_acc); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL b2b_in_ready got %b want 0", in_ready); else n_pass++;
        repeat (3) @(posedge clk); #1;
        n_total++; if (out_valid !== 1'b1 || out_alu_src2 !== 64'd1)
            $display("FAIL b2b_stall_hold got %b %h want 1 1", out_valid, out_alu_src2); else n_pass++;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_total++; if (out_valid !== 1'b1 || out_alu_src2 !== 64'(k + 1) || out_pc !== 64'(k * 4))
                $display("FAIL b2b_order%0d got %b %h %h want 1 %h %h", k, out_valid, out_alu_src2, out_pc,
                         64'(k + 1), 64'(k * 4)); else n_pass++;
            @(posedge clk); #1;
        end
        n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL b2b_empty got valid %b ready %b want 0 1", out_valid, in_ready); else n_pass++;
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; in_inst = 32'h0050_0093;
        repeat (2) @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_full got valid %b ready %b want 0 1", out_valid, in_ready); else n_pass++;
        repeat (3) @(posedge clk); #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush_stale got %b want 0", out_valid); else n_pass++;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        idle();
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush_accept got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1; in_inst = 32'h1234_5037; in_pc = 64'h44;
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; idle();
        n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rstmid_hs got valid %b ready %b want 0 1", out_valid, in_ready); else n_pass++;
        n_total++; if ({out_alu_control, out_alu_src1, out_alu_src2, out_pc, out_illegal} !== '0)
            $display("FAIL rstmid_data got %h %h %h %h %b want 0", out_alu_control, out_alu_src1,
                     out_alu_src2, out_pc, out_illegal); else n_pass++;
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t cur;
        logic [31:0] inst;
        logic m_rdy, m_vld;
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            in_valid    = 1'($urandom_range(0, 1));
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 24) == 0);
            in_pc       = {$urandom, $urandom};
            in_rs1_data = {$urandom, $urandom};
            in_rs2_data = {$urandom, $urandom};
            gen(in_pc, in_rs1_data, in_rs2_data, inst, cur);
            in_inst = inst;
            @(negedge clk);
            m_rdy = (q.size() < 2);
            m_vld = (q.size() != 0);
            n_total++; if (in_ready !== m_rdy || out_valid !== m_vld)
                $display("FAIL rnd%0d_hs got ready %b valid %b want %b %b", cyc, in_ready, out_valid, m_rdy, m_vld);
                else n_pass++;
            if (m_vld) begin
                n_total++;
                if (out_alu_control !== q[0].ctrl || out_alu_src1 !== q[0].s1 || out_alu_src2 !== q[0].s2 ||
                    out_pc !== q[0].pc || out_illegal !== q[0].ill)
                    $display("FAIL rnd%0d_data got %h %h %h %h %b want %h %h %h %h %b", cyc, out_alu_control,
                             out_alu_src1, out_alu_src2, out_pc, out_illegal,
                             q[0].ctrl, q[0].s1, q[0].s2, q[0].pc, q[0].ill);
                else n_pass++;
            end
            if (flush) q.delete();
            else begin
                if (m_vld && out_ready) void'(q.pop_front());
                if (in_valid && m_rdy) q.push_back(cur);
            end
            @(posedge clk); #1;
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
